adc_decimator: RTL and testbench
================================

Name: adc_decimator

Overview:
- Boxcar decimator between the ADC pins and the raw-measurement RAM.
- Consumes the paired 12-bit A/B sample stream and sums 2^DEC_LOG2 consecutive samples per channel.
- Emits one signed {A,B} result pair per block over a valid/ready handshake.
- Stops after MEAS_POINTS results and raises done, so the RAM writer only ever sees averaged, two's-complement data.

Parameters:
- ADC_WIDTH, 12: width of each raw ADC channel.
- DEC_LOG2, 4: log2 of the decimation ratio. Legal range is 0..8; 0 means pass-through with format conversion.
- MEAS_POINTS, 4096: results per run. Legal range is 1..4096.
- OFFSET_BINARY, 1: 1 means raw samples are offset binary (MSB inverted to get two's complement); 0 means they are already two's complement.

Ports:
- clk, input, 1: single clock domain. Samples arrive synchronous to it.
- rst, input, 1: reset, asynchronous and active-high.
- start, input, 1: one-cycle pulse that begins a run. Accepted in any state.
- sample_valid, input, 1: adc_a/adc_b hold a new sample this cycle.
- adc_a, input, ADC_WIDTH: channel A raw sample.
- adc_b, input, ADC_WIDTH: channel B raw sample.
- out_valid, output, 1: out_a/out_b hold an unaccepted result.
- out_ready, input, 1: downstream accepts the result this cycle.
- out_a, output, ADC_WIDTH+DEC_LOG2: signed channel A sum.
- out_b, output, ADC_WIDTH+DEC_LOG2: signed channel B sum.
- out_idx, output, 12: index of the current result (0..MEAS_POINTS-1). Used as the RAM write address.
- busy, output, 1: high in ACCUM.
- done, output, 1: high in DONE.
- overrun, output, 1: sticky; a result was dropped because the output register was full.

Behaviour:
- Reset (async, rst=1) puts the FSM in IDLE and clears accumulators, sample counter, result counter, out_valid, out_a, out_b, out_idx, busy, done and overrun.
- FSM states:
  - IDLE: waits for start.
  - ACCUM: summing samples.
  - DONE: run complete, holds until next start.
- start in any state (including mid-ACCUM or DONE), on the same clock edge:
  - go to ACCUM;
  - clear accumulators, sample counter, result counter, out_valid and overrun.
  - A sample_valid asserted in the start cycle is ignored.
- sample_valid is ignored in IDLE and DONE.
- Format conversion: if OFFSET_BINARY=1, invert the sample MSB; then sign-extend the sample to ADC_WIDTH+DEC_LOG2.
- Accumulation in ACCUM on each sample_valid:
  - acc <= acc + sample, with the sample counter incrementing mod 2^DEC_LOG2.
  - The full-scale sum fits the width exactly, so no saturation logic is needed.
- Block end: on the sample where the counter equals 2^DEC_LOG2-1, acc+sample is the result and acc reloads to 0 in the same cycle. No dead cycle is allowed between blocks.
- Latency: the result appears on out_a/out_b with out_valid=1 one clock after the last contributing sample.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_a, out_b and out_idx are stable while out_valid=1 and out_ready=0.
  - out_valid drops the cycle after a transfer unless a new result loads in that same cycle.
- Simultaneous events:
  - A new result with out_valid=1 and out_ready=1 in the same cycle loads the new result, keeps out_valid=1 and increments out_idx.
  - A new result with out_valid=1 and out_ready=0 drops the new result; the old result is kept and overrun is set.
- Result counting: the result counter increments on every produced result, dropped or not. out_idx is the counter value latched with each loaded result.
- Termination: when the result counter reaches MEAS_POINTS, go to DONE.
  - The pending final result stays valid until accepted.
  - done=1 and busy=0 from the cycle after the last result is produced.
- With DEC_LOG2=0, every valid sample produces a result (1-cycle latency).

Test Plan:
1. Defaults; start, then 16 samples A=0x800 B=0x7FF, out_ready=1 → one result, out_a=0, out_b=-16 (0xFFF0), out_idx=0, one cycle after the 16th sample.
2. 32 back-to-back samples A=0xFFF B=0x000, out_ready=1 → two results: out_a=16·2047=32752 (0x7FF0) and out_b=16·(-2048)=-32768 (0x8000); out_idx 0 then 1, no gap between blocks, overrun=0.
3. Hold out_ready=0 across two full blocks → first result held stable; second dropped; overrun=1. Raising out_ready transfers the first result (out_idx=0), and the next result carries out_idx=2.
4. Set MEAS_POINTS=3, DEC_LOG2=0, continuous samples → results idx 0,1,2; done=1 and busy=0 after the third sample; further sample_valid produces nothing.
5. Assert start mid-block (after 7 samples) → accumulators clear; the next 16 samples form a result with out_idx=0 and no contribution from the earlier 7.
6. Assert rst asynchronously mid-ACCUM with out_valid=1 → all outputs zero immediately (before the next edge); FSM in IDLE; samples ignored until start.

Source files
------------

// File: rtl/adc_decimator.sv
// adc_decimator: boxcar-sums 2^DEC_LOG2 paired ADC samples into signed {A,B} results over valid/ready
module adc_decimator #(
    parameter int ADC_WIDTH     = 12,
    parameter int DEC_LOG2      = 4,
    parameter int MEAS_POINTS   = 4096,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          sample_valid,
    input  logic [ADC_WIDTH-1:0]          adc_a,
    input  logic [ADC_WIDTH-1:0]          adc_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADC_WIDTH+DEC_LOG2-1:0] out_a,
    output logic [ADC_WIDTH+DEC_LOG2-1:0] out_b,
    output logic [11:0]                   out_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);
    localparam int OW = ADC_WIDTH + DEC_LOG2;
    localparam int CW = DEC_LOG2 > 0 ? DEC_LOG2 : 1;
    localparam logic [ADC_WIDTH-1:0] FLIP = OFFSET_BINARY != 0 ? {1'b1, {(ADC_WIDTH-1){1'b0}}} : '0;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                       state_q, state_d;
    logic        [OW-1:0]         acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic        [OW-1:0]         out_a_q, out_a_d, out_b_q, out_b_d;
    logic        [OW-1:0]         sum_a, sum_b;
    logic signed [ADC_WIDTH-1:0]  conv_a, conv_b;
    logic        [CW-1:0]         cnt_q, cnt_d;
    logic        [12:0]           res_q, res_d;
    logic        [11:0]           idx_q, idx_d;
    logic                         valid_q, valid_d, ovr_q, ovr_d, last;

    assign conv_a = adc_a ^ FLIP;
    assign conv_b = adc_b ^ FLIP;
    assign sum_a  = acc_a_q + OW'(conv_a);
    assign sum_b  = acc_b_q + OW'(conv_b);
    // with DEC_LOG2=0 every sample closes a block
    assign last   = (DEC_LOG2 == 0) || (cnt_q == {CW{1'b1}});

    always_comb begin
        state_d = state_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = valid_q && !out_ready;
        ovr_d   = ovr_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        idx_d   = idx_q;
        if (start) begin
            state_d = ACCUM;
            acc_a_d = '0;
            acc_b_d = '0;
            cnt_d   = '0;
            res_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (state_q == ACCUM && sample_valid) begin
            acc_a_d = last ? '0 : sum_a;
            acc_b_d = last ? '0 : sum_b;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            if (last) begin
                res_d   = res_q + 13'd1;
                state_d = res_d == 13'(MEAS_POINTS) ? DONE : ACCUM;
                // a full, unaccepted output register wins; the new result is lost
                if (!valid_q || out_ready) begin
                    valid_d = 1'b1;
                    out_a_d = sum_a;
                    out_b_d = sum_b;
                    idx_d   = res_q[11:0];
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_a_q <= '0;
            acc_b_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_idx   = idx_q;
    assign overrun   = ovr_q;
    assign busy      = state_q == ACCUM;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_adc_decimator.sv
// tb_adc_decimator: directed checks of the default decimator and a DEC_LOG2=0, MEAS_POINTS=3 instance
module tb_adc_decimator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] adc_a = '0;
    logic [11:0] adc_b = '0;
    logic        out_ready = 1'b0;

    logic        out_valid, busy, done, overrun;
    logic [15:0] out_a, out_b;
    logic [11:0] out_idx;
    logic        v0, busy0, done0, ovr0;
    logic [11:0] a0, b0, idx0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_decimator dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .adc_a(adc_a), .adc_b(adc_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_idx(out_idx), .busy(busy), .done(done),
        .overrun(overrun)
    );

    adc_decimator #(.DEC_LOG2(0), .MEAS_POINTS(3)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .adc_a(adc_a), .adc_b(adc_b), .out_valid(v0), .out_ready(out_ready),
        .out_a(a0), .out_b(b0), .out_idx(idx0), .busy(busy0), .done(done0),
        .overrun(ovr0)
    );

    typedef struct {
        logic [11:0] a0, a1, b0, b1;
        logic [15:0] ea, eb;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic samples(input int n, input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            adc_a = a;
            adc_b = b;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{a0: 12'hFFF, a1: 12'hFFF, b0: 12'h000, b1: 12'h000, ea: 16'h7FF0, eb: 16'h8000};
        vecs[1] = '{a0: 12'h800, a1: 12'h800, b0: 12'h7FF, b1: 12'h7FF, ea: 16'h0000, eb: 16'hFFF0};
        vecs[2] = '{a0: 12'hFFF, a1: 12'h000, b0: 12'h801, b1: 12'h7FF, ea: 16'hFFF8, eb: 16'h0000};
        vecs[3] = '{a0: 12'h123, a1: 12'h123, b0: 12'hABC, b1: 12'h801, ea: 16'h9230, eb: 16'h15E8};

        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy_done", {busy, done, overrun}, 0);
        chk("rst_idx", out_idx, 0);
        rst = 1'b0;
        tick();

        // single block, latency exactly one clock after the 16th sample
        out_ready = 1'b1;
        pulse_start();
        chk("t1_busy", busy, 1);
        samples(15, 12'h800, 12'h7FF);
        chk("t1_not_early", out_valid, 0);
        samples(1, 12'h800, 12'h7FF);
        chk("t1_valid", out_valid, 1);
        chk("t1_a", out_a, 16'h0000);
        chk("t1_b", out_b, 16'hFFF0);
        chk("t1_idx", out_idx, 0);

        // back-to-back blocks from the table, no dead cycle between them
        pulse_start();
        foreach (vecs[k]) begin
            for (int i = 0; i < 16; i++) begin
                sample_valid = 1'b1;
                adc_a = i[0] ? vecs[k].a1 : vecs[k].a0;
                adc_b = i[0] ? vecs[k].b1 : vecs[k].b0;
                tick();
                if (i == 0 && k > 0) chk("tbl_drop", out_valid, 0);
            end
            chk("tbl_valid", out_valid, 1);
            chk("tbl_a", out_a, vecs[k].ea);
            chk("tbl_b", out_b, vecs[k].eb);
            chk("tbl_idx", out_idx, k);
            chk("tbl_ovr", overrun, 0);
        end
        sample_valid = 1'b0;

        // backpressure: second result dropped, overrun, idx skips
        pulse_start();
        out_ready = 1'b0;
        samples(16, 12'hFFF, 12'h000);
        chk("t3_valid", out_valid, 1);
        chk("t3_a1", out_a, 16'h7FF0);
        samples(16, 12'h800, 12'h7FF);
        chk("t3_hold_a", out_a, 16'h7FF0);
        chk("t3_hold_b", out_b, 16'h8000);
        chk("t3_hold_idx", out_idx, 0);
        chk("t3_ovr", overrun, 1);
        out_ready = 1'b1;
        tick();
        chk("t3_xfer", out_valid, 0);
        samples(16, 12'h801, 12'h801);
        chk("t3_a3", out_a, 16'h0010);
        chk("t3_idx3", out_idx, 2);
        chk("t3_ovr_sticky", overrun, 1);

        // pass-through instance, run of three results then DONE
        pulse_start();
        chk("t4_busy", busy0, 1);
        samples(1, 12'hFFF, 12'h800);
        chk("t4_r0", {v0, a0, b0, idx0}, {1'b1, 12'h7FF, 12'h000, 12'd0});
        samples(1, 12'h000, 12'h801);
        chk("t4_r1", {v0, a0, b0, idx0}, {1'b1, 12'h800, 12'h001, 12'd1});
        chk("t4_not_done", done0, 0);
        samples(1, 12'h7FF, 12'h800);
        chk("t4_r2", {v0, a0, b0, idx0}, {1'b1, 12'hFFF, 12'h000, 12'd2});
        chk("t4_done", {done0, busy0}, 2'b10);
        samples(1, 12'h123, 12'h456);
        chk("t4_ignored", {v0, a0, done0}, {1'b0, 12'hFFF, 1'b1});

        // restart mid-block discards partial sums and the start-cycle sample
        pulse_start();
        samples(7, 12'hFFF, 12'hFFF);
        start = 1'b1;
        sample_valid = 1'b1;
        adc_a = 12'hFFF;
        adc_b = 12'hFFF;
        tick();
        start = 1'b0;
        samples(16, 12'h801, 12'h7FF);
        chk("t5_valid", out_valid, 1);
        chk("t5_a", out_a, 16'h0010);
        chk("t5_b", out_b, 16'hFFF0);
        chk("t5_idx", out_idx, 0);

        // asynchronous reset takes effect between clock edges
        out_ready = 1'b0;
        pulse_start();
        samples(32, 12'hFFF, 12'h000);
        samples(3, 12'hFFF, 12'h000);
        chk("t6_pre", {out_valid, overrun}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ab", {out_a, out_b}, 0);
        chk("t6_flags", {busy, done, overrun, out_idx}, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        samples(16, 12'hFFF, 12'hFFF);
        chk("t6_idle", {out_valid, busy, out_a}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
